bus2_line_master: RTL and testbench
===================================

# bus2_line_master

Cache-side initiator for bus2, the shared bus between the cache and MemCTR. Accepts one line-level read or write request from the cache core, issues C2_READ_LINE / C2_WRITE_LINE with the line address, streams the line 16 bits per cycle in the required direction, and waits for MemCTR's C2_RESPONSE before returning completion. The block owns A2/D2/C2 only while it is the bus2 master and tri-states them otherwise.

## Interface
- CACHE_LINE_SIZE, 16: line size in bytes; even; beats N = CACHE_LINE_SIZE/2.
- ADDR2_BUS_SIZE, 15: line-address width on A2.
- DATA_BUS_SIZE, 16: D2 width; fixed at 16.
- CTR2_BUS_SIZE, 2: C2 width.
- TIMEOUT_CYCLES, 255: response watchdog limit; used only with BUS2_TIMEOUT_EN.
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high in IDLE only.
- req_write  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR2_BUS_SIZE  line address (byte address >> offset bits).
- req_wdata  in  CACHE_LINE_SIZE*8  write line; byte k = req_wdata[8k+7:8k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  CACHE_LINE_SIZE*8  read line, same byte packing; held until next read completes.
- resp_err  out  1  valid with resp_valid; 1 = timeout.
- A2_WIRE  inout  ADDR2_BUS_SIZE  bus2 address.
- D2_WIRE  inout  DATA_BUS_SIZE  bus2 data.
- C2_WIRE  inout  CTR2_BUS_SIZE  bus2 command: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.

## Operation
- States: IDLE, CMD, WDATA, WAIT_RESP, RDATA, DONE.
- IDLE: req_ready=1; all bus2 drivers high-Z. On req_valid: latch req_write/req_addr/req_wdata, go to CMD.
- CMD (one cycle): drive C2=command, A2=req_addr; write also drives D2 = {byte1, byte0} (little-endian: lower-address byte on D2[7:0]). Next: write → WDATA (if N>1) else WAIT_RESP; read → WAIT_RESP.
- WDATA: beat i (1..N-1) drives D2={byte 2i+1, byte 2i}, C2=C2_NOP, A2 held; after beat N-1 → WAIT_RESP.
- WAIT_RESP: drivers high-Z; sample C2_WIRE each posedge. On C2_RESPONSE: write → DONE; read → capture D2 as beat 0, → RDATA (if N>1) else DONE. Other values ignored.
- RDATA: capture beats 1..N-1 on consecutive posedges unconditionally; after beat N-1 → DONE.
- DONE (one cycle): resp_valid=1, resp_err=0; → IDLE.
- req_valid outside IDLE is ignored; no queueing.
- Beat counter width clog2(N); wraps never (terminal compare at N-1).

## Timing
- Reset (RESET=0 at posedge): state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all bus2 drivers high-Z. Applies mid-transfer; no resp_valid for an aborted request; MemCTR side is not recovered by this block.
- Drive enables and bus values are registered; driving starts the cycle after acceptance.
- Write: command + beat 0 in cycle 1 after acceptance; beats end cycle N; bus released from cycle N+1; resp_valid one cycle after C2_RESPONSE sampled.
- Read: command cycle 1; released from cycle 2; response beat 0 at edge R; beats at R..R+N-1; resp_valid in cycle after R+N-1 with resp_rdata valid same cycle.
- Minimum gap between completions: 1 IDLE cycle (req_ready high the cycle after DONE).

## Configuration
- BUS2_TIMEOUT_EN defined: counter in WAIT_RESP; after TIMEOUT_CYCLES cycles without C2_RESPONSE → DONE with resp_err=1, resp_rdata unchanged. Counter clears on entry to WAIT_RESP.
- Undefined: no counter; WAIT_RESP waits indefinitely; resp_err tied 0.

## Test plan
- Write req_addr=0x5, line bytes 0x00..0x0F -> C2=3, A2=0x5, D2=0x0100 then 0x0302 … 0x0F0E over 8 cycles; responder asserts C2=1 after 50 cycles -> resp_valid one cycle later, resp_err=0.
- Read req_addr=0x12; responder returns C2=1 with D2=0xBBAA,0xDDCC,… -> resp_rdata byte0=0xAA, byte1=0xBB, byte2=0xCC; bus high-Z during wait.
- Back-to-back write then read with req_valid held high -> second accepted only after DONE; exactly two resp_valid pulses.
- RESET low during RDATA beat 3 -> next cycle IDLE, drivers high-Z, no resp_valid, resp_rdata=0.
- BUS2_TIMEOUT_EN, TIMEOUT_CYCLES=20, responder silent -> resp_valid with resp_err=1 exactly 20 cycles after entering WAIT_RESP; without macro, no resp_valid after 1000 cycles.
- Stray C2=1 from responder while IDLE -> ignored, no resp_valid.

Source files
------------

// File: rtl/bus2_line_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus2_line_master: cache-side bus2 initiator for line reads and writes.   |
// | Optional feature macro: BUS2_TIMEOUT_EN (response watchdog).             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus2_line_master #(
  parameter int CACHE_LINE_SIZE = 16,
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]     req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]  req_wdata,
  output logic                          resp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0]  resp_rdata,
  output logic                          resp_err,
  inout  wire  [ADDR2_BUS_SIZE-1:0]     A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]      D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]      C2_WIRE
);

  localparam int N  = CACHE_LINE_SIZE / 2;
  localparam int LW = CACHE_LINE_SIZE * 8;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_WDATA     = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_RDATA     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic                        wr_q, wr_d;
  logic [ADDR2_BUS_SIZE-1:0]   addr_q, addr_d;
  logic [LW-1:0]               wline_q, wline_d;
  logic [LW-1:0]               rline_q, rline_d;
  logic [LW-1:0]               rdata_q, rdata_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic                        a2_oe_q, a2_oe_d;
  logic                        d2_oe_q, d2_oe_d;
  logic                        c2_oe_q, c2_oe_d;
  logic [DATA_BUS_SIZE-1:0]    d2_out_q, d2_out_d;
  logic [CTR2_BUS_SIZE-1:0]    c2_out_q, c2_out_d;
  logic                        drive_beat;

`ifdef BUS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        err_q, err_d;
`else
  logic [31:0]                 unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    rdata_d    = rdata_q;
    beat_d     = beat_q;
    a2_oe_d    = 1'b0;
    d2_oe_d    = 1'b0;
    c2_oe_d    = 1'b0;
    d2_out_d   = d2_out_q;
    c2_out_d   = C2_NOP;
    drive_beat = 1'b0;
`ifdef BUS2_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif

    // Drive enables/values are computed for the next state so they are registered.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d     = req_write;
          addr_d   = req_addr;
          wline_d  = req_wdata;
          state_d  = S_CMD;
          a2_oe_d  = 1'b1;
          c2_oe_d  = 1'b1;
          c2_out_d = req_write ? C2_WRITE_LINE : C2_READ_LINE;
          d2_oe_d  = req_write;
          d2_out_d = req_wdata[DATA_BUS_SIZE-1:0];
`ifdef BUS2_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end

      S_CMD: begin
        if (wr_q && (N > 1)) begin
          state_d    = S_WDATA;
          beat_d     = BEAT_ONE;
          drive_beat = 1'b1;
        end else begin
          state_d    = S_WAIT_RESP;
        end
      end

      S_WDATA: begin
        if (beat_q == LAST_BEAT) begin
          state_d    = S_WAIT_RESP;
        end else begin
          beat_d     = beat_q + BEAT_ONE;
          drive_beat = 1'b1;
        end
      end

      S_WAIT_RESP: begin
        if (C2_WIRE == C2_RESPONSE) begin
          if (wr_q) begin
            state_d = S_DONE;
          end else begin
            rline_d[DATA_BUS_SIZE-1:0] = D2_WIRE;
            if (N > 1) begin
              state_d = S_RDATA;
              beat_d  = BEAT_ONE;
            end else begin
              state_d = S_DONE;
              rdata_d = rline_d;
            end
          end
        end
`ifdef BUS2_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q + TW'(1);
        end
`endif
      end

      S_RDATA: begin
        rline_d[DATA_BUS_SIZE*int'(beat_q) +: DATA_BUS_SIZE] = D2_WIRE;
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
          rdata_d = rline_d;
        end else begin
          beat_d  = beat_q + BEAT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (drive_beat) begin
      a2_oe_d  = 1'b1;
      c2_oe_d  = 1'b1;
      d2_oe_d  = 1'b1;
      c2_out_d = C2_NOP;
      d2_out_d = wline_q[DATA_BUS_SIZE*int'(beat_d) +: DATA_BUS_SIZE];
    end

`ifdef BUS2_TIMEOUT_EN
    // Holding the counter at zero outside WAIT_RESP gives a clean start on every entry.
    if (state_q != S_WAIT_RESP) begin
      tmo_d = '0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rdata_q <= '0;
      a2_oe_q <= 1'b0;
      d2_oe_q <= 1'b0;
      c2_oe_q <= 1'b0;
`ifdef BUS2_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      a2_oe_q <= a2_oe_d;
      d2_oe_q <= d2_oe_d;
      c2_oe_q <= c2_oe_d;
`ifdef BUS2_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Datapath holding registers are only observed once qualified by state or enables.
  always_ff @(posedge CLK) begin
    wr_q     <= wr_d;
    addr_q   <= addr_d;
    wline_q  <= wline_d;
    rline_q  <= rline_d;
    d2_out_q <= d2_out_d;
    c2_out_q <= c2_out_d;
  end

  assign A2_WIRE = a2_oe_q ? addr_q   : 'z;
  assign D2_WIRE = d2_oe_q ? d2_out_q : 'z;
  assign C2_WIRE = c2_oe_q ? c2_out_q : 'z;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = rdata_q;

`ifdef BUS2_TIMEOUT_EN
  assign resp_err = (state_q == S_DONE) && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus2_line_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus2_line_master: directed bench with a transaction-timing model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bus2_line_master;

  localparam int N   = 8;
  localparam int LW  = 128;
  localparam int AW  = 15;
  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           RESET;
  logic           req_valid;
  logic           req_write;
  logic [AW-1:0]  req_addr;
  logic [LW-1:0]  req_wdata;
  wire            req_ready;
  wire            resp_valid;
  wire [LW-1:0]   resp_rdata;
  wire            resp_err;
  wire [AW-1:0]   a2;
  wire [15:0]     d2;
  wire [1:0]      c2;

  logic           rsp_c2_en;
  logic [1:0]     rsp_c2;
  logic           rsp_d2_en;
  logic [15:0]    rsp_d2;

  assign c2 = rsp_c2_en ? rsp_c2 : 'z;
  assign d2 = rsp_d2_en ? rsp_d2 : 'z;

  bus2_line_master #(
    .CACHE_LINE_SIZE(16),
    .ADDR2_BUS_SIZE (AW),
    .DATA_BUS_SIZE  (16),
    .CTR2_BUS_SIZE  (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (clk),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .A2_WIRE    (a2),
    .D2_WIRE    (d2),
    .C2_WIRE    (c2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_resp   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each transaction is described by its acceptance edge, the start of
  // its response window and its completion cycle; outputs follow from those.
  initial begin : compare_proc
    int            e, acc, ws, resp_p, done, idx;
    bit            minit, busy, m_wr, m_err;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_line, rline, exp_rdata;
    bit            s_rv, s_rst, s_wr;
    logic [1:0]    s_c2;
    logic [15:0]   s_d2;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_wd;
    logic [AW-1:0] exp_a2;
    logic [1:0]    exp_c2;
    logic [15:0]   exp_d2;
    bit            exp_valid;
    e = 0; acc = 0; ws = 0; resp_p = -1; done = -1;
    minit = 0; busy = 0; m_wr = 0; m_err = 0;
    m_addr = '0; m_line = '0; rline = '0; exp_rdata = '0;
    forever begin
      @(negedge clk);
      s_rv = req_valid; s_rst = RESET; s_wr = req_write;
      s_c2 = c2; s_d2 = d2; s_addr = req_addr; s_wd = req_wdata;
      @(posedge clk);
      e++;
      if (!s_rst) begin
        minit = 1; busy = 0; exp_rdata = '0; resp_p = -1; done = -1;
      end else if (busy) begin
        if (done >= 0 && e == done + 1) begin
          busy = 0;
        end else if (done < 0 && e > ws) begin
          if (s_c2 == 2'd1) begin
            resp_p = e;
            done   = m_wr ? e : e + N - 1;
          end
`ifdef BUS2_TIMEOUT_EN
          else if (e == ws + TMO) begin
            done  = e;
            m_err = 1;
          end
`endif
        end
        if (resp_p >= 0 && !m_wr && (e - resp_p) < N) rline[16*(e-resp_p) +: 16] = s_d2;
        if (busy && done >= 0 && e == done && !m_wr && !m_err) exp_rdata = rline;
      end else if (s_rv) begin
        busy = 1; acc = e; m_wr = s_wr; m_addr = s_addr; m_line = s_wd;
        ws = e + (s_wr ? N : 1); resp_p = -1; done = -1; m_err = 0;
      end
      #2;
      if (minit) begin
        exp_valid = busy && done >= 0 && e == done;
        exp_a2 = '0; exp_c2 = 2'd0; exp_d2 = 16'd0;
        if (busy && e >= acc && e < acc + (m_wr ? N : 1)) begin
          idx    = e - acc;
          exp_a2 = m_addr;
          exp_c2 = (idx == 0) ? (m_wr ? 2'd3 : 2'd2) : 2'd0;
          exp_d2 = m_wr ? m_line[16*idx +: 16] : 16'd0;
        end
        check("req_ready", LW'(req_ready), LW'(!busy));
        check("resp_valid", LW'(resp_valid), LW'(exp_valid));
        check("resp_err", LW'(resp_err), LW'(exp_valid && m_err));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("A2", LW'(a2), LW'(exp_a2));
        if (!rsp_c2_en) check("C2", LW'(c2), LW'(exp_c2));
        if (!rsp_d2_en) check("D2", LW'(d2), LW'(exp_d2));
        if (resp_valid === 1'b1) n_resp++;
      end
    end
  end

  task automatic drive_beats(input logic [LW-1:0] line, input int nb);
    for (int j = 0; j < nb; j++) begin
      rsp_d2_en = 1'b1;
      rsp_d2    = line[16*j +: 16];
      rsp_c2_en = (j == 0);
      rsp_c2    = 2'd1;
      tick();
    end
    rsp_d2_en = 1'b0;
    rsp_c2_en = 1'b0;
  endtask

  initial begin : stim
    logic [LW-1:0] wl, rl, rl2, rl3;
    int base;
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_c2_en = 1'b0; rsp_c2 = 2'd0; rsp_d2_en = 1'b0; rsp_d2 = 16'd0;
    for (int k = 0; k < 16; k++) begin
      wl[8*k +: 8]  = 8'(k);
      rl[8*k +: 8]  = 8'hAA + 8'(8'h11 * k);
      rl2[8*k +: 8] = 8'h51 + 8'(3 * k);
      rl3[8*k +: 8] = 8'h30 + 8'(k);
    end
    repeat (3) tick();
    check("rst_ready", LW'(req_ready), LW'(1));
    check("rst_valid", LW'(resp_valid), LW'(0));
    check("rst_rdata", resp_rdata, '0);
    check("rst_a2_released", LW'(a2), LW'(0));
    RESET = 1'b1;
    tick();

    // Stray response while idle
    rsp_c2_en = 1'b1; rsp_c2 = 2'd1; rsp_d2_en = 1'b1; rsp_d2 = 16'h1234;
    repeat (3) tick();
    rsp_c2_en = 1'b0; rsp_d2_en = 1'b0;
    tick();
    check("stray_no_resp", LW'(n_resp), LW'(0));
    check("stray_ready", LW'(req_ready), LW'(1));

    // Line write to address 0x5
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h5; req_wdata = wl;
    tick();
    req_valid = 1'b0;
    check("wr_cmd_c2", LW'(c2), LW'(3));
    check("wr_cmd_a2", LW'(a2), LW'(15'h5));
    check("wr_beat0", LW'(d2), LW'(16'h0100));
    tick();
    check("wr_beat1", LW'(d2), LW'(16'h0302));
    check("wr_beat1_c2", LW'(c2), LW'(0));
    repeat (N - 2) tick();
    check("wr_beat7", LW'(d2), LW'(16'h0F0E));
    tick();
    check("wr_released_a2", LW'(a2), LW'(0));
    repeat (50) tick();
    rsp_c2_en = 1'b1; rsp_c2 = 2'd1;
    tick();
    rsp_c2_en = 1'b0;
    check("wr_done_valid", LW'(resp_valid), LW'(1));
    check("wr_done_err", LW'(resp_err), LW'(0));
    tick();
    check("wr_idle_ready", LW'(req_ready), LW'(1));

    // Line read from address 0x12
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h12;
    tick();
    req_valid = 1'b0;
    check("rd_cmd_c2", LW'(c2), LW'(2));
    check("rd_cmd_a2", LW'(a2), LW'(15'h12));
    tick();
    check("rd_wait_a2_released", LW'(a2), LW'(0));
    repeat (4) tick();
    drive_beats(rl, N);
    check("rd_done_valid", LW'(resp_valid), LW'(1));
    check("rd_byte0", LW'(resp_rdata[7:0]), LW'(8'hAA));
    check("rd_byte1", LW'(resp_rdata[15:8]), LW'(8'hBB));
    check("rd_byte2", LW'(resp_rdata[23:16]), LW'(8'hCC));
    tick();

    // Back-to-back write then read with req_valid held high
    base = n_resp;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h2A; req_wdata = ~wl;
    tick();
    req_write = 1'b0; req_addr = 15'h21;
    check("b2b_wr_cmd", LW'(c2), LW'(3));
    repeat (N) tick();
    rsp_c2_en = 1'b1; rsp_c2 = 2'd1;
    tick();
    rsp_c2_en = 1'b0;
    check("b2b_wr_done", LW'(resp_valid), LW'(1));
    check("b2b_busy_in_done", LW'(req_ready), LW'(0));
    tick();
    check("b2b_idle_gap", LW'(req_ready), LW'(1));
    tick();
    check("b2b_rd_cmd_c2", LW'(c2), LW'(2));
    check("b2b_rd_cmd_a2", LW'(a2), LW'(15'h21));
    req_valid = 1'b0;
    tick();
    drive_beats(rl2, N);
    check("b2b_rd_done", LW'(resp_valid), LW'(1));
    check("b2b_rd_line", resp_rdata, rl2);
    repeat (2) tick();
    check("b2b_two_pulses", LW'(n_resp - base), LW'(2));

    // Reset while the fourth read beat is on the bus
    base = n_resp;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h33;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    drive_beats(rl3, 3);
    rsp_d2_en = 1'b1; rsp_d2 = rl3[48 +: 16];
    RESET = 1'b0;
    tick();
    rsp_d2_en = 1'b0;
    RESET = 1'b1;
    check("rst_mid_ready", LW'(req_ready), LW'(1));
    check("rst_mid_valid", LW'(resp_valid), LW'(0));
    check("rst_mid_rdata", resp_rdata, '0);
    check("rst_mid_a2", LW'(a2), LW'(0));
    repeat (N + 4) tick();
    check("rst_mid_no_resp", LW'(n_resp - base), LW'(0));

    // Silent responder
    base = n_resp;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h44;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef BUS2_TIMEOUT_EN
    repeat (TMO - 1) tick();
    check("tmo_not_yet", LW'(resp_valid), LW'(0));
    tick();
    check("tmo_valid", LW'(resp_valid), LW'(1));
    check("tmo_err", LW'(resp_err), LW'(1));
    check("tmo_rdata_kept", resp_rdata, '0);
    repeat (2) tick();
    check("tmo_one_pulse", LW'(n_resp - base), LW'(1));
`else
    repeat (1000) tick();
    check("no_tmo_no_resp", LW'(n_resp - base), LW'(0));
    check("no_tmo_still_busy", LW'(req_ready), LW'(0));
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("no_tmo_recovered", LW'(req_ready), LW'(1));
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
